// File: rtl/mul_booth_stage_pkg.sv
// Shared constants and Booth digit decoding for the 32x32 multiplier front stage.
package mul_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NPP     = XLEN / 2 + 1;
  localparam int unsigned NCOL    = 2 * XLEN;
  localparam int unsigned XW      = XLEN + 2;
  localparam int unsigned SLICE_W = 17;
  localparam int unsigned CIN_W   = 14;

  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_P1   = 3'd1,
    BD_P2   = 3'd2,
    BD_M1   = 3'd3,
    BD_M2   = 3'd4
  } booth_digit_e;

  function automatic booth_digit_e booth_decode(input logic [2:0] b);
    booth_digit_e d;
    unique case (b)
      3'b001, 3'b010: d = BD_P1;
      3'b011:         d = BD_P2;
      3'b100:         d = BD_M2;
      3'b101, 3'b110: d = BD_M1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mul_booth_stage_booth_sel.sv
// Radix-4 Booth partial-product selector: one's-complemented multiple of X' plus negate flag.
module booth_sel
  import mul_pkg::*;
(
  input  logic [2:0]    sel,
  input  logic [XW-1:0] xe,
  output logic [XW-1:0] pp,
  output logic          neg
);

  booth_digit_e digit;
  logic [XW-1:0] mag;

  always_comb begin
    digit = booth_decode(sel);
    mag   = '0;
    neg   = 1'b0;
    unique case (digit)
      BD_P1:   mag = xe;
      BD_P2:   mag = {xe[XW-2:0], 1'b0};
      BD_M1: begin
        mag = xe;
        neg = 1'b1;
      end
      BD_M2: begin
        mag = {xe[XW-2:0], 1'b0};
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    // +1 of the two's complement is deferred to the carry-in paths
    pp = neg ? ~mag : mag;
  end

endmodule

// File: rtl/mul_booth_stage.sv
// Booth-encode Y, select 17 partial products of X, transpose to 64 columns, register with valid/ready.
module mul_booth_stage
  import mul_pkg::*;
(
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mul_signed,
  input  logic [XLEN-1:0]           x,
  input  logic [XLEN-1:0]           y,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NCOL*SLICE_W-1:0]   col_w,
  output logic [CIN_W-1:0]          cin_col0,
  output logic                      adder_cin,
  output logic                      c_lsb
);

  logic              ext_x;
  logic              ext_y;
  logic [XW-1:0]     xe;
  logic [XLEN+2:0]   ye;
  logic [XW-1:0]     pp     [NPP];
  logic [NCOL-1:0]   pp_row [NPP];
  logic [NPP-1:0]    neg;
  logic [NCOL*SLICE_W-1:0] col_next;
  logic              accept;

  assign ext_x = mul_signed & x[XLEN-1];
  assign ext_y = mul_signed & y[XLEN-1];
  assign xe    = {ext_x, ext_x, x};
  assign ye    = {ext_y, ext_y, y, 1'b0};

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  genvar j, i;
  generate
    for (j = 0; j < NPP; j++) begin : g_pp
      booth_sel u_sel (
        .sel (ye[2*j +: 3]),
        .xe  (xe),
        .pp  (pp[j]),
        .neg (neg[j])
      );
      assign pp_row[j] = {{(NCOL-XW){pp[j][XW-1]}}, pp[j]} << (2*j);
      for (i = 0; i < NCOL; i++) begin : g_col
        assign col_next[i*SLICE_W + j] = pp_row[j][i];
      end
    end
  endgenerate

  // Top Booth digit sees {ext,ext,y[31]}: 000/001 unsigned, 000/111 signed -- never negative.
  always_comb begin
    assert (neg[NPP-1] == 1'b0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      col_w     <= '0;
      cin_col0  <= '0;
      adder_cin <= 1'b0;
      c_lsb     <= 1'b0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (accept)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;

      if (accept && !flush) begin
        col_w     <= col_next;
        cin_col0  <= neg[CIN_W-1:0];
        adder_cin <= neg[CIN_W];
        c_lsb     <= neg[CIN_W+1];
      end
    end
  end

endmodule
